// File: rtl/req_onehot_arbiter.sv
// Round-robin arbiter over 8 asynchronous request lines: synchronizes and edge/level-detects
// each line, keeps a pending vector and hands out one-hot grants held until acknowledged.
module req_onehot_arbiter #(
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic       grant_ack,
  output logic [7:0] grant_out,
  output logic       grant_valid,
  output logic [7:0] pending,
  output logic       drop_pulse
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;
  logic [7:0] s3_q, s3_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] gidx_q, gidx_d;
  logic [2:0] ptr_q, ptr_d;
  logic       drop_q, drop_d;

  logic [7:0] evt;
  logic [7:0] clr;
  logic       accept;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand_idx;

  // State register: every flop, including the synchronizer chain, clears asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all flops sample the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
    end
  end

  // Synchronizer, event detection and pending bookkeeping.
  always_comb begin
    s1_d   = req_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    accept = (state_q == ST_GRANT) && grant_ack;
    clr    = accept ? grant_q : 8'h00;
    evt    = (EDGE_MODE != 0) ? (s2_q & ~s3_q) : s2_q;
    // A set on the same bit as an accepted clear wins, so no request is ever lost.
    pending_d = (pending_q & ~clr) | evt;
    drop_d    = |(evt & pending_q & ~clr);
  end

  // Round-robin search: first set pending bit at or after ptr, wrapping 7 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand_idx   = ptr_q;
    for (int off = 0; off < 8; off++) begin
      cand_idx = ptr_q + off[2:0];
      if (!pick_found && pending_q[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          grant_d = 8'h01 << pick_idx;
          gidx_d  = pick_idx;
        end
      end
      ST_GRANT: begin
        if (grant_ack) begin
          state_d = ST_IDLE;
          grant_d = 8'h00;
          ptr_d   = gidx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  // Outputs come straight from flops, so an asynchronous reset drops them at once.
  always_comb begin
    grant_valid = (state_q == ST_GRANT);
    grant_out   = grant_valid ? grant_q : 8'h00;
    pending     = pending_q;
    drop_pulse  = drop_q;
  end

endmodule
